// File: rtl/switch_conditioner.sv
// switch_conditioner: per-lane synchroniser, debouncer and press/release/long-press pulse generator
// feeding clean levels and single-cycle events to the LFSR block.
module switch_conditioner #(
    parameter int NUM_SW            = 2,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int LONG_PRESS_CYCLES = 25000000,
    parameter bit PRESS_LEVEL       = 1'b1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NUM_SW-1:0] i_sw,
    output logic [NUM_SW-1:0] o_level,
    output logic [NUM_SW-1:0] o_press,
    output logic [NUM_SW-1:0] o_release,
    output logic [NUM_SW-1:0] o_long
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = $clog2(LONG_PRESS_CYCLES) + 1;
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HMAX = HW'(LONG_PRESS_CYCLES);
    typedef enum logic [1:0] {REL, DEB_P, PRS, DEB_R} state_t;
    for (genvar g = 0; g < NUM_SW; g++) begin : lane
        logic [SYNC_STAGES-1:0] sync_q;
        state_t                 st;
        logic [DW-1:0]          deb;
        logic [HW-1:0]          hold;
        logic                   lvl_q, prs_q, rel_q, lng_q;
        logic                   p, rel_commit;
        assign p          = sync_q[SYNC_STAGES-1] == PRESS_LEVEL;
        assign rel_commit = st == DEB_R && !p && deb == DMAX;
        assign o_level[g]   = lvl_q;
        assign o_press[g]   = prs_q;
        assign o_release[g] = rel_q;
        assign o_long[g]    = lng_q;
        always_ff @(posedge CLK or negedge RST_N)
            if (!RST_N) sync_q <= {SYNC_STAGES{~PRESS_LEVEL}};
            else        sync_q <= {sync_q[SYNC_STAGES-2:0], i_sw[g]};
        always_ff @(posedge CLK or negedge RST_N)
            if (!RST_N) begin
                st    <= REL;
                deb   <= '0;
                hold  <= '0;
                lvl_q <= 1'b0;
                prs_q <= 1'b0;
                rel_q <= 1'b0;
                lng_q <= 1'b0;
            end else begin
                prs_q <= 1'b0;
                rel_q <= 1'b0;
                lng_q <= 1'b0;
                case (st)
                    REL: if (p) begin
                        st  <= DEB_P;
                        deb <= DW'(1);
                    end
                    DEB_P: if (!p) begin
                        st  <= REL;
                        deb <= '0;
                    end else if (deb == DMAX) begin
                        st    <= PRS;
                        deb   <= '0;
                        hold  <= '0;
                        lvl_q <= 1'b1;
                        prs_q <= 1'b1;
                    end else deb <= deb + 1'b1;
                    PRS: if (!p) begin
                        st  <= DEB_R;
                        deb <= DW'(1);
                    end
                    default: if (p) begin
                        st  <= PRS;
                        deb <= '0;
                    end else if (deb == DMAX) begin
                        st    <= REL;
                        deb   <= '0;
                        lvl_q <= 1'b0;
                        rel_q <= 1'b1;
                    end else deb <= deb + 1'b1;
                endcase
                // a committing release clears the hold and outranks a coinciding long-press
                if (rel_commit) hold <= '0;
                else if ((st == PRS || st == DEB_R) && hold != HMAX) begin
                    hold  <= hold + 1'b1;
                    lng_q <= hold + 1'b1 == HMAX;
                end
            end
    end
endmodule

// File: tb/tb_switch_conditioner.sv
// tb_switch_conditioner: directed and random stimulus scored against a sliding-window reference model.
module tb_switch_conditioner;
    localparam int SYNC = 2, DEB = 4, LONG = 20, NSW = 2;
    localparam int WIN = SYNC + DEB + 1;
    logic           CLK = 1'b0;
    logic           RST_N = 1'b0;
    logic [NSW-1:0] i_sw = '0;
    logic [NSW-1:0] o_level, o_press, o_release, o_long;
    int n_cmp = 0, n_bad = 0, edge_n = 0;
    int np [NSW], nr [NSW], nl [NSW], press_e [NSW], rel_e [NSW], long_e [NSW];
    logic [7:0]     exp_q [$];
    logic [WIN-1:0] h [NSW];
    logic [NSW-1:0] m_lvl = '0;
    int             press_t [NSW];

    switch_conditioner #(
        .NUM_SW(NSW), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
        .LONG_PRESS_CYCLES(LONG), .PRESS_LEVEL(1'b1)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .i_sw(i_sw),
        .o_level(o_level), .o_press(o_press), .o_release(o_release), .o_long(o_long)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (edge %0d)", nm, act, want, edge_n);
        end
    endtask

    // A lane's level flips once the sampled pin has held the opposite value for
    // DEB+1 consecutive samples, seen SYNC edges late; long fires LONG edges after the press.
    always @(posedge CLK) begin
        logic [NSW-1:0] pr, rl, lg;
        logic [DEB:0]   w;
        edge_n++;
        pr = '0;
        rl = '0;
        lg = '0;
        if (!RST_N) begin
            m_lvl = '0;
            for (int l = 0; l < NSW; l++) h[l] = '0;
        end else
            for (int l = 0; l < NSW; l++) begin
                h[l] = {h[l][WIN-2:0], i_sw[l]};
                w = h[l][WIN-1:SYNC];
                if (!m_lvl[l] && &w) begin
                    m_lvl[l] = 1'b1;
                    pr[l] = 1'b1;
                    press_t[l] = edge_n;
                end else if (m_lvl[l] && ~|w) begin
                    m_lvl[l] = 1'b0;
                    rl[l] = 1'b1;
                end else if (m_lvl[l] && edge_n - press_t[l] == LONG) lg[l] = 1'b1;
            end
        exp_q.push_back({m_lvl, pr, rl, lg});
    end

    always @(negedge CLK) begin
        logic [7:0] e;
        if (exp_q.size() == 0) chk("scoreboard_empty", 0, 1);
        else begin
            e = exp_q.pop_front();
            if (!RST_N) e = '0;
            chk("outputs{level,press,release,long}", int'({o_level, o_press, o_release, o_long}), int'(e));
        end
        for (int l = 0; l < NSW; l++) begin
            if (o_press[l])   begin np[l]++; press_e[l] = edge_n; end
            if (o_release[l]) begin nr[l]++; rel_e[l] = edge_n; end
            if (o_long[l])    begin nl[l]++; long_e[l] = edge_n; end
        end
    end

    task automatic drive(input logic [NSW-1:0] v, input int n);
        i_sw = v;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        for (int l = 0; l < NSW; l++) begin
            np[l] = 0; nr[l] = 0; nl[l] = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        logic [NSW-1:0] v;
        clr();
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        drive(2'b00, 5);
        // clean press on lane 0
        clr();
        s = edge_n + 1;
        drive(2'b01, 12);
        chk("clean_press_edge", press_e[0], s + 6);
        chk("clean_press_count", np[0], 1);
        chk("clean_lane1_silent", np[1] + nr[1] + nl[1], 0);
        drive(2'b00, 12);
        chk("clean_release_count", nr[0], 1);
        // bounce rejected
        clr();
        for (int i = 0; i < 4; i++) drive(i % 2 == 0 ? 2'b01 : 2'b00, 3);
        drive(2'b00, 12);
        chk("bounce_reject_activity", np[0] + nr[0] + nl[0], 0);
        // bounce then held
        clr();
        for (int i = 0; i < 4; i++) drive(i % 2 == 0 ? 2'b01 : 2'b00, 3);
        s = edge_n + 1;
        drive(2'b01, 12);
        chk("bounce_accept_press_count", np[0], 1);
        chk("bounce_accept_press_edge", press_e[0], s + 6);
        chk("bounce_accept_no_release", nr[0], 0);
        drive(2'b00, 12);
        // long press on lane 1
        clr();
        s = edge_n + 1;
        drive(2'b10, 40);
        drive(2'b00, 12);
        chk("long_press_edge", press_e[1], s + 6);
        chk("long_count", nl[1], 1);
        chk("long_delay", long_e[1] - press_e[1], LONG);
        chk("long_release_edge", rel_e[1], s + 46);
        // release commit coincides with hold count LONG
        clr();
        drive(2'b01, 20);
        drive(2'b00, 12);
        chk("race_release_count", nr[0], 1);
        chk("race_long_suppressed", nl[0], 0);
        chk("race_release_at_long", rel_e[0] - press_e[0], LONG);
        // reset while the press candidate is being counted
        clr();
        drive(2'b01, 4);
        RST_N = 1'b0;
        #1 chk("reset_async_outputs", int'({o_level, o_press, o_release, o_long}), 0);
        repeat (5) @(posedge CLK);
        #1 RST_N = 1'b1;
        s = edge_n + 1;
        drive(2'b01, 12);
        chk("reset_repress_edge", press_e[0], s + 6);
        chk("reset_no_release", nr[0], 0);
        // reset while stably pressed, switch still held
        RST_N = 1'b0;
        #1 chk("reset_drops_level", int'(o_level), 0);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        drive(2'b01, 12);
        drive(2'b00, 12);
        chk("reset_held_press_count", np[0], 2);
        chk("reset_held_release_count", nr[0], 1);
        // random traffic, independent lanes, occasional reset
        for (int i = 0; i < 400; i++) begin
            v = NSW'($urandom);
            drive(v, $urandom_range(0, 3) == 0 ? $urandom_range(15, 30) : $urandom_range(1, 8));
            if ($urandom_range(0, 39) == 0) begin
                RST_N = 1'b0;
                repeat (2) @(posedge CLK);
                #1 RST_N = 1'b1;
            end
        end
        drive(2'b00, 12);
        repeat (2) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
